gf180mcu_fd_sc_mcu9t5v0__sync_debounce: RTL and testbench

GF180MCU_FD_SC_MCU9T5V0__SYNC_DEBOUNCE -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__sync_debounce

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__sync_debounce.sv | 134 +++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__sync_debounce.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_debounce.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__sync_debounce
//
// Purpose:
//   Brings an asynchronous raw level D into the CLK domain through a plain
//   flop synchronizer chain. It then filters the synchronized level S with a
//   consecutive-cycle debounce counter. Q only follows S after S has differed
//   from Q for DEBOUNCE consecutive enabled cycles. RISE/FALL are one-cycle
//   registered pulses that mark each Q transition. BUSY shows that a candidate
//   change is being counted.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth (2..4)
//   CNT_W       : debounce counter width (2..8)
//   DEBOUNCE    : consecutive stable enabled cycles required (1..2^CNT_W-1)
//   RESET_VAL   : level held by the sync chain and Q while in reset
//
// Ports:
//   CLK  in  : single clock, rising edge
//   RST  in  : asynchronous active-high reset
//   D    in  : asynchronous raw level
//   EN   in  : filter enable, synchronous to CLK
//   Q    out : debounced registered level
//   RISE out : one-cycle pulse after Q goes 0->1
//   FALL out : one-cycle pulse after Q goes 1->0
//   BUSY out : debounce counter is nonzero
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__sync_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned DEBOUNCE    = 8,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    input  logic EN,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    // Counter value at which the next mismatching enabled cycle commits S to
    // Q. With DEBOUNCE=1 this is zero, so the counter never leaves zero.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchronizer chain; bit 0 samples D, the top bit is S.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_s;

    // Debounce state.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             q_q;
    logic             q_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Decode helpers.
    logic differ_s;
    logic expire_s;

    // Pure shift of the synchronizer; nothing sits between the stages.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], D};
    end

    // Synchronizer flops. They shift every edge, whatever the value of EN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s_s      = sync_q[SYNC_STAGES-1];
    assign differ_s = s_s ^ q_q;
    assign expire_s = (cnt_q == CNT_LAST);

    // Debounce next-state. The counter measures the current run of enabled
    // cycles in which S has disagreed with Q. It commits when the run reaches
    // DEBOUNCE and clears as soon as S agrees with Q again. When disabled,
    // everything holds except the pulses, which drop.
    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (EN) begin
            if (!differ_s) begin
                cnt_d = CNT_ZERO;
            end else if (expire_s) begin
                q_d    = s_s;
                cnt_d  = CNT_ZERO;
                rise_d = s_s;
                fall_d = ~s_s;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
            q_d   = q_q;
        end
    end

    // Debounce state flops. Reset overrides a Q update in the same cycle and
    // produces no edge pulse of its own.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= CNT_ZERO;
            q_q    <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign Q    = q_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
    assign BUSY = (cnt_q != CNT_ZERO);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__sync_debounce.sv
// -----------------------------------------------------------------------------
// Testbench for gf180mcu_fd_sc_mcu9t5v0__sync_debounce.
// There are four instances with different parameters:
//   0: SYNC 2, DEBOUNCE 4,  RESET_VAL 0
//   1: SYNC 2, DEBOUNCE 4,  RESET_VAL 1
//   2: SYNC 2, DEBOUNCE 1,  RESET_VAL 0
//   3: SYNC 2, DEBOUNCE 15, RESET_VAL 0
// A behavioural model predicts every output on every cycle. Literal
// latency/pulse expectations pin the model.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__sync_debounce;

    localparam int SYN = 2;

    logic       clk = 1'b0;
    logic [3:0] rst_v;
    logic [3:0] d_v;
    logic [3:0] en_v;
    logic       q_o    [4];
    logic       rise_o [4];
    logic       fall_o [4];
    logic       busy_o [4];

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__sync_debounce #(.SYNC_STAGES(2), .CNT_W(4), .DEBOUNCE(4), .RESET_VAL(1'b0)) u0 (
        .CLK(clk), .RST(rst_v[0]), .D(d_v[0]), .EN(en_v[0]),
        .Q(q_o[0]), .RISE(rise_o[0]), .FALL(fall_o[0]), .BUSY(busy_o[0]));
    gf180mcu_fd_sc_mcu9t5v0__sync_debounce #(.SYNC_STAGES(2), .CNT_W(4), .DEBOUNCE(4), .RESET_VAL(1'b1)) u1 (
        .CLK(clk), .RST(rst_v[1]), .D(d_v[1]), .EN(en_v[1]),
        .Q(q_o[1]), .RISE(rise_o[1]), .FALL(fall_o[1]), .BUSY(busy_o[1]));
    gf180mcu_fd_sc_mcu9t5v0__sync_debounce #(.SYNC_STAGES(2), .CNT_W(4), .DEBOUNCE(1), .RESET_VAL(1'b0)) u2 (
        .CLK(clk), .RST(rst_v[2]), .D(d_v[2]), .EN(en_v[2]),
        .Q(q_o[2]), .RISE(rise_o[2]), .FALL(fall_o[2]), .BUSY(busy_o[2]));
    gf180mcu_fd_sc_mcu9t5v0__sync_debounce #(.SYNC_STAGES(2), .CNT_W(4), .DEBOUNCE(15), .RESET_VAL(1'b0)) u3 (
        .CLK(clk), .RST(rst_v[3]), .D(d_v[3]), .EN(en_v[3]),
        .Q(q_o[3]), .RISE(rise_o[3]), .FALL(fall_o[3]), .BUSY(busy_o[3]));

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: D history, debounced level, run length of disagreement.
    logic [7:0] hist [4];
    bit         qm   [4];
    bit         rm   [4];
    bit         fm   [4];
    int         run  [4];

    // Statistics gathered while a scenario runs.
    int         first_q [4];
    bit         qprev   [4];
    int         rise_n  [4];
    int         fall_n  [4];
    int         busy_n  [4];
    int         rise_e0;
    logic [7:0] busy_mask0;

    function automatic int deb_of(input int k);
        case (k)
            0: return 4;
            1: return 4;
            2: return 1;
            3: return 15;
            default: return 4;
        endcase
    endfunction

    function automatic bit rv_of(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        hist[k] = {8{rv_of(k)}};
        qm[k]   = rv_of(k);
        rm[k]   = 1'b0;
        fm[k]   = 1'b0;
        run[k]  = 0;
    endtask

    task automatic model_reset_all();
        for (int k = 0; k < 4; k++) model_reset(k);
    endtask

    // Behavioural rule: S is D delayed by SYN edges. Q takes S once S has
    // disagreed with Q on DEBOUNCE consecutive enabled edges.
    task automatic model_step();
        bit s;
        for (int k = 0; k < 4; k++) begin
            if (rst_v[k]) begin
                model_reset(k);
            end else begin
                s     = hist[k][SYN-1];
                rm[k] = 1'b0;
                fm[k] = 1'b0;
                if (en_v[k]) begin
                    if (s == qm[k]) begin
                        run[k] = 0;
                    end else begin
                        run[k] = run[k] + 1;
                        if (run[k] >= deb_of(k)) begin
                            qm[k]  = s;
                            run[k] = 0;
                            rm[k]  = s;
                            fm[k]  = !s;
                        end
                    end
                end
                hist[k] = {hist[k][6:0], d_v[k]};
            end
        end
    endtask

    // One clock: advance the model at the edge, compare everything mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("q[%0d]", k),    32'(q_o[k]),    32'(qm[k]));
            chk($sformatf("rise[%0d]", k), 32'(rise_o[k]), 32'(rm[k]));
            chk($sformatf("fall[%0d]", k), 32'(fall_o[k]), 32'(fm[k]));
            chk($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(run[k] != 0));
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 4; k++) begin
            first_q[k] = 0;
            qprev[k]   = rv_of(k);
            rise_n[k]  = 0;
            fall_n[k]  = 0;
            busy_n[k]  = 0;
        end
        rise_e0    = 0;
        busy_mask0 = 8'h00;
    endtask

    task automatic observe(input int e);
        for (int k = 0; k < 4; k++) begin
            if (first_q[k] == 0 && q_o[k] !== qprev[k]) first_q[k] = e;
            qprev[k]  = q_o[k];
            rise_n[k] = rise_n[k] + int'(rise_o[k]);
            fall_n[k] = fall_n[k] + int'(fall_o[k]);
            busy_n[k] = busy_n[k] + int'(busy_o[k]);
        end
        if (rise_o[0] === 1'b1 && rise_e0 == 0) rise_e0 = e;
        if (e >= 1 && e <= 8 && busy_o[0] === 1'b1) busy_mask0[e-1] = 1'b1;
    endtask

    // Entered at a negedge. Reset is asserted between edges and held for two
    // edges, then released away from the clock edge.
    task automatic apply_reset(input logic [3:0] dval);
        #2;
        rst_v = 4'hF;
        model_reset_all();
        d_v  = dval;
        en_v = 4'hF;
        tick();
        tick();
        rst_v = 4'h0;
    endtask

    initial begin
        logic [39:0] dp;
        logic [23:0] ep;
        int          win;

        rst_v = 4'hF;
        d_v   = 4'b0010;
        en_v  = 4'hF;
        model_reset_all();
        @(negedge clk);

        // Reset state, pinned literally.
        apply_reset(4'b0010);
        chk("rst_q0", 32'(q_o[0]), 32'd0);
        chk("rst_q1", 32'(q_o[1]), 32'd1);
        chk("rst_busy0", 32'(busy_o[0]), 32'd0);
        chk("rst_rise1", 32'(rise_o[1]), 32'd0);
        chk("rst_fall1", 32'(fall_o[1]), 32'd0);

        // Latency: inst 0 and 2 and 3 see D 0->1, inst 1 sees D 1->0.
        clear_stats();
        d_v = 4'b1101;
        for (int e = 1; e <= 20; e++) begin
            tick();
            observe(e);
        end
        chk("lat_q0", first_q[0], 6);
        chk("rise_edge0", rise_e0, 6);
        chk("rise_cnt0", rise_n[0], 1);
        chk("busy_mask0", 32'(busy_mask0), 32'h1C);
        chk("lat_q1_fall", first_q[1], 6);
        chk("fall_cnt1", fall_n[1], 1);
        chk("rise_cnt1", rise_n[1], 0);
        chk("lat_q2_deb1", first_q[2], 3);
        chk("busy_cnt2", busy_n[2], 0);
        chk("lat_q3_deb15", first_q[3], 17);
        chk("busy_cnt3", busy_n[3], 14);
        chk("q3_final", 32'(q_o[3]), 32'd1);

        // Short pulse of 3 cycles is rejected with DEBOUNCE=4, passes with DEBOUNCE=1.
        apply_reset(4'b0010);
        clear_stats();
        for (int e = 1; e <= 14; e++) begin
            d_v = (e <= 3) ? 4'b1101 : 4'b0010;
            tick();
            observe(e);
        end
        chk("pulse_rise0", rise_n[0], 0);
        chk("pulse_q0", 32'(q_o[0]), 32'd0);
        chk("pulse_busy_n0", busy_n[0], 3);
        chk("pulse_busy_end0", 32'(busy_o[0]), 32'd0);
        chk("pulse_fall1", fall_n[1], 0);
        chk("pulse_rise2", rise_n[2], 1);
        chk("pulse_fall2", fall_n[2], 1);

        // Enable gap: EN=0 on edges 4..8 freezes the count.
        apply_reset(4'b0010);
        clear_stats();
        d_v = 4'b1101;
        win = 0;
        for (int e = 1; e <= 16; e++) begin
            en_v[0] = !(e >= 4 && e <= 8);
            tick();
            observe(e);
            if (e >= 4 && e <= 8 && busy_o[0] === 1'b1) win++;
        end
        en_v = 4'hF;
        chk("en_lat_q0", first_q[0], 11);
        chk("en_busy_win0", win, 5);
        chk("en_busy_n0", busy_n[0], 8);
        chk("en_rise0", rise_n[0], 1);

        // Reset mid-count clears at once and restarts the full latency.
        apply_reset(4'b0010);
        d_v = 4'b1111;
        for (int e = 1; e <= 4; e++) tick();
        chk("pre_rst_busy0", 32'(busy_o[0]), 32'd1);
        #2;
        rst_v = 4'hF;
        model_reset_all();
        #1;
        chk("mid_rst_busy0", 32'(busy_o[0]), 32'd0);
        chk("mid_rst_q0", 32'(q_o[0]), 32'd0);
        chk("mid_rst_rise0", 32'(rise_o[0]), 32'd0);
        chk("mid_rst_fall0", 32'(fall_o[0]), 32'd0);
        tick();
        rst_v = 4'h0;
        clear_stats();
        for (int e = 1; e <= 10; e++) begin
            tick();
            observe(e);
        end
        chk("post_rst_lat_q0", first_q[0], 6);
        chk("post_rst_rise0", rise_n[0], 1);

        // Noisy D with scattered EN drops, checked against the model only.
        dp = 40'b1111_1110_0011_1111_1100_0010_1101_1111_0000_0100;
        ep = 24'b1111_1011_1111_1111_0111_1111;
        for (int e = 0; e < 80; e++) begin
            for (int k = 0; k < 4; k++) begin
                d_v[k]  = dp[(e + 3 * k) % 40];
                en_v[k] = ep[(e + k) % 24];
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
